period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 165 ++++++++++++++++
 tb/tb_period_meter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
// period_meter: measures the half-period of a divided square wave in clk_in cycles.
// Define PERIOD_METER_SYNC_EN to add a two-flop synchronizer on sig_in.
module period_meter #(
  parameter int CNT_W = 27
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             enable,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] meas_value,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             locked,
  output logic             overflow,
  output logic             meas_lost
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    COUNT
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] last;
  logic             have_last;
  logic             sig_s;
  logic             sig_q;
  logic             edge_det;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             res_ld;
  logic             ovf_set;
  logic             hist_clr;
  logic             xfer;

`ifdef PERIOD_METER_SYNC_EN
  logic [1:0] sync;

  // two-flop synchronizer ahead of edge detection
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) sync <= 2'b00;
    else        sync <= {sync[0], sig_in};
  end

  assign sig_s = sync[1];
`else
  assign sig_s = sig_in;
`endif

  assign edge_det = sig_s ^ sig_q;
  assign xfer     = meas_valid & meas_ready;

  // edge history: previous sampled level
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_s;
  end

  // state register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // next state and datapath controls; disable overrides everything
  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    res_ld   = 1'b0;
    ovf_set  = 1'b0;
    hist_clr = 1'b0;
    if (!enable) begin
      state_nx = IDLE;
      cnt_clr  = 1'b1;
      hist_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          state_nx = ARMED;
          cnt_clr  = 1'b1;
        end
        ARMED: begin
          if (edge_det) begin
            state_nx = COUNT;
            cnt_clr  = 1'b1;
            hist_clr = 1'b1;
          end
        end
        COUNT: begin
          if (edge_det) begin
            res_ld  = 1'b1;
            cnt_clr = 1'b1;
          end else if (&cnt) begin
            ovf_set  = 1'b1;
            cnt_clr  = 1'b1;
            hist_clr = 1'b1;
            state_nx = ARMED;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_nx = IDLE;
          cnt_clr  = 1'b1;
        end
      endcase
    end
  end

  // measurement counter
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)       cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else if (cnt_inc) cnt <= cnt + ONE;
  end

  // result register with valid/ready hold; a new result always loads
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      meas_value <= '0;
      meas_valid <= 1'b0;
    end else if (res_ld) begin
      meas_value <= cnt;
      meas_valid <= 1'b1;
    end else if (xfer) begin
      meas_valid <= 1'b0;
    end
  end

  // lock tracking: compare each result with the one before it
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      last      <= '0;
      have_last <= 1'b0;
      locked    <= 1'b0;
    end else if (hist_clr) begin
      have_last <= 1'b0;
      locked    <= 1'b0;
    end else if (res_ld) begin
      last      <= cnt;
      have_last <= 1'b1;
      locked    <= have_last & (cnt == last);
    end
  end

  // sticky flags; a set beats a simultaneous clear
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      meas_lost <= 1'b0;
    end else begin
      overflow  <= ovf_set | (overflow & ~clr_flags);
      meas_lost <= (res_ld & meas_valid & ~meas_ready)
                 | (meas_lost & ~clr_flags);
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: scoreboard bench for period_meter (CNT_W=4).
// Results are queued at stimulus time and checked on each transfer.
module tb_period_meter;

  localparam int W = 4;
`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sig_in = 1'b0;
  logic         enable = 1'b0;
  logic         clr_flags = 1'b0;
  logic         meas_ready = 1'b1;
  logic [W-1:0] meas_value;
  logic         meas_valid;
  logic         locked;
  logic         overflow;
  logic         meas_lost;

  typedef struct packed {
    logic [7:0] v;
    logic       lk;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  period_meter #(.CNT_W(W)) dut (
    .clk_in    (clk),
    .rst_n     (rst_n),
    .sig_in    (sig_in),
    .enable    (enable),
    .clr_flags (clr_flags),
    .meas_value(meas_value),
    .meas_valid(meas_valid),
    .meas_ready(meas_ready),
    .locked    (locked),
    .overflow  (overflow),
    .meas_lost (meas_lost)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int g);
    step(g);
    sig_in = ~sig_in;
  endtask

  task automatic expect_res(input int v, input bit lk);
    exp_t e;
    e.v  = 8'(v);
    e.lk = lk;
    exp_q.push_back(e);
  endtask

  // monitor: every transfer must match the head of the scoreboard
  always @(negedge clk) begin
    if (rst_n && meas_valid && meas_ready) begin
      chk("result_expected", int'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_value", int'(meas_value), int'(e.v));
        chk("result_locked", int'(locked), int'(e.lk));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int k;
    #1;
    chk("rst_value", int'(meas_value), 0);
    chk("rst_valid", int'(meas_valid), 0);
    chk("rst_locked", int'(locked), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_lost", int'(meas_lost), 0);
    step(2);
    rst_n  = 1'b1;
    enable = 1'b1;
    step(1);

    // toggle 4, always ready
    pulse(1);
    for (int i = 0; i < 4; i++) begin
      expect_res(4, i > 0);
      pulse(5);
    end
    step(LAT);
    chk("t4_locked", int'(locked), 1);

    // toggle change 4 -> 6
    expect_res(6, 0);
    pulse(7 - LAT);
    step(LAT);
    chk("t6_first_unlocked", int'(locked), 0);
    expect_res(6, 1);
    pulse(7 - LAT);
    step(LAT);
    chk("t6_second_locked", int'(locked), 1);

    // toggle 2 with consumer stalled
    step(1);
    meas_ready = 1'b0;
    pulse(2);
    pulse(3);
    pulse(3);
    pulse(3);
    step(LAT);
    chk("stall_valid", int'(meas_valid), 1);
    chk("stall_value", int'(meas_value), 2);
    chk("stall_lost", int'(meas_lost), 1);
    chk("stall_locked", int'(locked), 1);
    expect_res(2, 1);
    meas_ready = 1'b1;
    step(1);
    chk("valid_cleared", int'(meas_valid), 0);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    chk("lost_cleared", int'(meas_lost), 0);

    // static input: counter saturates
    k = 0;
    while (!overflow && k < 40) begin
      step(1);
      k++;
    end
    chk("ovf_cycles", k, 14);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_no_valid", int'(meas_valid), 0);
    chk("ovf_unlocked", int'(locked), 0);
    pulse(1);
    expect_res(4, 0);
    pulse(5);
    step(LAT);
    chk("ovf_sticky", int'(overflow), 1);
    clr_flags = 1'b1;
    step(1);
    clr_flags = 1'b0;
    chk("ovf_cleared", int'(overflow), 0);
    expect_res(4, 1);
    pulse(4 - LAT);
    step(LAT);
    chk("relock", int'(locked), 1);

    // enable dropped mid-count
    step(2);
    enable = 1'b0;
    step(1);
    chk("dis_unlocked", int'(locked), 0);
    step(3);
    enable = 1'b1;
    step(1);
    pulse(2);
    expect_res(4, 0);
    pulse(5);
    expect_res(4, 1);
    pulse(5);
    step(LAT);
    chk("reen_locked", int'(locked), 1);

    // reset mid-count with a pending result
    step(1);
    meas_ready = 1'b0;
    pulse(4 - LAT);
    step(LAT);
    chk("pre_rst_valid", int'(meas_valid), 1);
    step(2);
    rst_n  = 1'b0;
    sig_in = 1'b0;
    #1;
    chk("mid_rst_value", int'(meas_value), 0);
    chk("mid_rst_valid", int'(meas_valid), 0);
    chk("mid_rst_locked", int'(locked), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    chk("mid_rst_lost", int'(meas_lost), 0);
    step(1);
    rst_n      = 1'b1;
    meas_ready = 1'b1;
    step(1);
    pulse(2);
    expect_res(4, 0);
    pulse(5);
    k = 0;
    while (!meas_valid && k < 10) begin
      step(1);
      k++;
    end
    chk("latency", k, LAT);
    step(3);
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
